unary_add_seq: RTL and testbench
================================

# unary_add_seq

Sequencer that drives one serial unary adder from binary operands. Accepts a pair of binary counts over a valid/ready handshake and expands each into a thermometer bitstream. It runs the adder's read (accumulate) phase, then its write (emit) phase, and counts the emitted ones back into a binary sum. Sits between the binary-side datapath and the unary adder instance; the adder's clock and reset come from the same domain.

## Interface
- `CNT_W`, 4, operand width in bits
- `STREAM_LEN`, 15, bitstream length in cycles for both the read and write phases; must satisfy `STREAM_LEN <= 2**CNT_W - 1`
- `DOUT_LAT`, 1, cycles from the first write-phase cycle until the adder's first valid `dout` bit
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  operand pair offered
- `op_ready`  out  1  sequencer can accept an operand pair
- `op_a`, `op_b`  in  `CNT_W`  binary operands (count of ones)
- `res_valid`  out  1  result held
- `res_ready`  in  1  consumer takes the result
- `res_sum`  out  `CNT_W+1`  ones counted on `add_dout`
- `res_ovf`  out  1  `add_c` was seen high during the write phase
- `add_rst_n`  out  1  adder reset; registered, low in `IDLE`
- `add_en`, `add_rw`, `add_a`, `add_b`  out  1  adder enable, read(0)/write(1), and input bitstreams
- `add_dout`, `add_c`  in  1  adder serial output and carry/saturation flag
- `abort`  in  1  present only with `UNARY_SEQ_ABORT_EN`

## Operation
- FSM states are `IDLE`, `READ`, `WRITE`, `DONE`.
- **Reset:** state=`IDLE`. `op_ready`=1, `res_valid`=0, `res_sum`=0, `res_ovf`=0. `add_rst_n`=0, `add_en`=0, `add_rw`=0, `add_a`=0, `add_b`=0. Cycle counter=0.
- **`IDLE`:**
  - `op_ready`=1.
  - On `op_valid && op_ready`: latch `op_a`/`op_b`, saturating each to `STREAM_LEN`. Clear `res_sum` and `res_ovf`, then go to `READ`.
- **`READ`:**
  - Lasts `STREAM_LEN` cycles; counter i runs 0..`STREAM_LEN`-1.
  - Outputs: `add_en`=1, `add_rw`=0, `add_a`=(i < a), `add_b`=(i < b).
  - After the last cycle, go to `WRITE`.
- **`WRITE`:**
  - Lasts `STREAM_LEN`+`DOUT_LAT` cycles; counter j runs 0..`STREAM_LEN`+`DOUT_LAT`-1.
  - Outputs: `add_en`=1, `add_rw`=1, `add_a`=`add_b`=0.
  - For j ≥ `DOUT_LAT`, `res_sum` += `add_dout`.
  - `res_ovf` |= `add_c` on every `WRITE` cycle.
  - Go to `DONE` after the last cycle.
- **`DONE`:**
  - `res_valid`=1, `add_en`=0; `res_sum` and `res_ovf` are stable.
  - On `res_ready`: go to `IDLE`.
- `op_ready`=0 in every state except `IDLE`. A new operand pair is never accepted in the same cycle a result is consumed.
- **Arithmetic:** `res_sum` ≤ `STREAM_LEN`; it cannot wrap because the width is `CNT_W+1`. Saturation of a+b above `STREAM_LEN` shows up as `res_ovf`, not in `res_sum`.
- **Boundaries:**
  - a=0 drives `add_a` low for the whole `READ` phase.
  - a=`STREAM_LEN` drives `add_a` high for the whole `READ` phase.
  - An operand above `STREAM_LEN` is clamped to `STREAM_LEN`.
  - `rst_n` asserted mid-operation returns the FSM to `IDLE` immediately and drops `add_rst_n`; no partial result is presented.

## Timing
- All outputs are registered.
- Handshake accepted on edge k → first `READ` cycle is k+1.
- First `WRITE` cycle is k+1+`STREAM_LEN`.
- `res_valid` rises at k+1+2·`STREAM_LEN`+`DOUT_LAT`; with defaults that is k+32.
- Throughput is one operation per 2·`STREAM_LEN`+`DOUT_LAT`+2 cycles when `res_ready` is held high.
- `add_rst_n` deasserts on the same edge that enters `READ`.

## Configuration
- `UNARY_SEQ_ABORT_EN` defined:
  - Port `abort` exists.
  - `abort`=1 in `READ` or `WRITE` sends the FSM to `IDLE` on the next edge, with `add_en`=0 and `add_rst_n`=0.
  - No result is presented.
  - `abort` in `IDLE` or `DONE` is ignored.
- `UNARY_SEQ_ABORT_EN` undefined: the port is absent and every accepted operation runs to `DONE`.

## Structure
- Shared package `unary_pkg`: state enum (`IDLE`/`READ`/`WRITE`/`DONE`) and default constants `UNARY_CNT_W`=4, `UNARY_STREAM_LEN`=15.
- One sub-module, `unary_stream_gen`: compares the latched count against the shared counter to emit the thermometer bit. Instantiated twice, for a and for b.

## Test plan
- a=3, b=5, adder model correct → `add_a` high in `READ` cycles 0–2 and `add_b` in cycles 0–4; `res_sum`=8, `res_ovf`=0; `res_valid` at k+32.
- a=15, b=15, model saturates and asserts `add_c` → `res_sum`=15, `res_ovf`=1.
- a=0, b=0 → `add_a`=`add_b`=0 throughout; `res_sum`=0.
- `res_ready` held low for 5 cycles after `DONE` → `res_valid`/`res_sum` stable, `op_ready`=0 and a pending `op_valid` not accepted; `op_ready` returns the cycle after `res_ready`.
- `rst_n` pulsed low at `WRITE` cycle 4 → all outputs at reset values, state `IDLE`; the next op (a=2, b=2) gives `res_sum`=4.
- With `UNARY_SEQ_ABORT_EN`: `abort` at `READ` cycle 7 → `IDLE` next edge, no `res_valid`, `add_en`=0.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared definitions for the unary adder sequencer: FSM state encoding,
// default sizing constants and the operand clamp helper.
package unary_pkg;

    // Default operand width and bitstream length
    localparam int UNARY_CNT_W      = 4;
    localparam int UNARY_STREAM_LEN = 15;

    // Sequencer phases: wait for operands, accumulate, emit, hold result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } unary_state_e;

    // A count can never exceed the number of cycles in the stream
    function automatic int unsigned clamp_count(int unsigned value, int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/unary_stream_gen.sv
// Thermometer bit generator: the stream is high while the shared phase
// counter is below the latched count, so a count of n gives n leading ones.
module unary_stream_gen #(
    parameter int CNT_W = 4,
    parameter int IDX_W = 4
) (
    input  logic             en_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             bit_o
);

    // Compare at a common width so CNT_W and IDX_W may differ
    always_comb begin
        bit_o = en_i && (32'(idx_i) < 32'(count_i));
    end

endmodule

// File: rtl/unary_add_seq.sv
// Sequencer driving one serial unary adder from binary operands.
// Accepts an operand pair, streams both as thermometer codes through the
// adder's read phase, then counts the ones it emits in the write phase.
// Optional feature: define UNARY_SEQ_ABORT_EN to add the abort input.
module unary_add_seq
    import unary_pkg::*;
#(
    parameter int CNT_W      = UNARY_CNT_W,
    parameter int STREAM_LEN = UNARY_STREAM_LEN,
    parameter int DOUT_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [CNT_W-1:0] op_a,
    input  logic [CNT_W-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W:0]   res_sum,
    output logic             res_ovf,
    output logic             add_rst_n,
    output logic             add_en,
    output logic             add_rw,
    output logic             add_a,
    output logic             add_b,
    input  logic             add_dout,
    input  logic             add_c
`ifdef UNARY_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    // The counter must reach the last write-phase index
    localparam int CTR_W = (STREAM_LEN + DOUT_LAT > 1) ? $clog2(STREAM_LEN + DOUT_LAT) : 1;
    localparam logic [CTR_W-1:0] READ_LAST   = CTR_W'(STREAM_LEN - 1);
    localparam logic [CTR_W-1:0] WRITE_LAST  = CTR_W'(STREAM_LEN + DOUT_LAT - 1);
    localparam logic [CTR_W-1:0] FIRST_VALID = CTR_W'(DOUT_LAT);

    unary_state_e     state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0] a_q, a_d;
    logic [CNT_W-1:0] b_q, b_d;
    logic [CNT_W:0]   sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             add_rst_n_q, add_rst_n_d;
    logic             add_en_q, add_en_d;
    logic             add_rw_q, add_rw_d;
    logic             add_a_q, add_a_d;
    logic             add_b_q, add_b_d;
    logic             abort_hit;

`ifdef UNARY_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Phase sequencing, operand capture and write-phase result accumulation
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        ctr_d   = ctr_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (op_valid && op_ready_q) begin
                    a_d     = CNT_W'(clamp_count(32'(op_a), 32'(STREAM_LEN)));
                    b_d     = CNT_W'(clamp_count(32'(op_b), 32'(STREAM_LEN)));
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    ctr_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort_hit) begin
                    ctr_d   = '0;
                    state_d = IDLE;
                end else if (ctr_q == READ_LAST) begin
                    ctr_d   = '0;
                    state_d = WRITE;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            WRITE: begin
                ovf_d = ovf_q | add_c;
                // Bits before the adder's output latency has elapsed are not data
                if ((ctr_q >= FIRST_VALID) && add_dout) begin
                    sum_d = sum_q + (CNT_W + 1)'(1);
                end
                if (abort_hit) begin
                    ctr_d   = '0;
                    state_d = IDLE;
                end else if (ctr_q == WRITE_LAST) begin
                    ctr_d   = '0;
                    state_d = DONE;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Thermometer bits for the cycle being entered, registered with the state
    unary_stream_gen #(.CNT_W(CNT_W), .IDX_W(CTR_W)) u_gen_a (
        .en_i    (state_d == READ),
        .count_i (a_d),
        .idx_i   (ctr_d),
        .bit_o   (add_a_d)
    );

    unary_stream_gen #(.CNT_W(CNT_W), .IDX_W(CTR_W)) u_gen_b (
        .en_i    (state_d == READ),
        .count_i (b_d),
        .idx_i   (ctr_d),
        .bit_o   (add_b_d)
    );

    // Output values are decoded from the next state so every output is a flop
    always_comb begin
        op_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        add_rst_n_d = (state_d != IDLE);
        add_en_d    = (state_d == READ) || (state_d == WRITE);
        add_rw_d    = (state_d == WRITE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            add_rst_n_q <= 1'b0;
            add_en_q    <= 1'b0;
            add_rw_q    <= 1'b0;
            add_a_q     <= 1'b0;
            add_b_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            add_rst_n_q <= add_rst_n_d;
            add_en_q    <= add_en_d;
            add_rw_q    <= add_rw_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_sum   = sum_q;
    assign res_ovf   = ovf_q;
    assign add_rst_n = add_rst_n_q;
    assign add_en    = add_en_q;
    assign add_rw    = add_rw_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

endmodule

// File: tb/tb_unary_add_seq.sv
// Testbench for unary_add_seq with a behavioural unary adder attached.
module tb_unary_add_seq;

    localparam int L  = 15;
    localparam int DL = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_sum;
    logic       res_ovf;
    logic       add_rst_n;
    logic       add_en;
    logic       add_rw;
    logic       add_a;
    logic       add_b;
    logic       add_dout;
    logic       add_c;
    logic       abort;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    unary_add_seq #(.CNT_W(4), .STREAM_LEN(L), .DOUT_LAT(DL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_ovf   (res_ovf),
        .add_rst_n (add_rst_n),
        .add_en    (add_en),
        .add_rw    (add_rw),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_dout  (add_dout),
        .add_c     (add_c)
`ifdef UNARY_SEQ_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Behavioural unary adder: counts input ones while reading, then emits
    // min(total, L) ones one cycle after each write cycle; flags totals above L.
    int m_acc;
    int m_widx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !add_rst_n) begin
            m_acc    <= 0;
            m_widx   <= 0;
            add_dout <= 1'b0;
            add_c    <= 1'b0;
        end else if (add_en && !add_rw) begin
            m_acc <= m_acc + int'(add_a) + int'(add_b);
        end else if (add_en && add_rw) begin
            add_dout <= (m_widx < ((m_acc > L) ? L : m_acc));
            add_c    <= (m_acc > L);
            m_widx   <= m_widx + 1;
        end else begin
            add_dout <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every output at its reset value: op_ready=1, all others 0
    task automatic check_reset_outputs(input string name);
        logic [12:0] exp_v;
        exp_v = {1'b1, 12'b0};
        check(name, {19'b0, op_ready, res_valid, res_sum, res_ovf,
                     add_rst_n, add_en, add_rw, add_a, add_b}, {19'b0, exp_v});
    endtask

    // Offer an operand pair and return the edge number that accepted it
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input bit hold, output int k);
        int budget;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        budget = 0;
        while (!op_ready && budget < 100) begin
            tick();
            budget++;
        end
        check("accept_ready", {31'b0, op_ready}, 32'd1);
        tick();
        k = edge_cnt;
        if (!hold) op_valid = 1'b0;
        // first READ cycle: adder out of reset, result cleared, no new operands
        check("first_read", {22'b0, add_en, add_rw, add_rst_n, op_ready, res_ovf, res_sum},
              {22'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0});
    endtask

    // Watch the operation through READ/WRITE up to res_valid and check it
    task automatic finish_op(input string tag, input int k, input logic [4:0] es,
                             input logic eo, input logic [15:0] am, input logic [15:0] bm);
        int budget, rd_n, wr_n, bad_w;
        logic [15:0] amask, bmask;
        budget = 0; rd_n = 0; wr_n = 0; bad_w = 0;
        amask = '0; bmask = '0;
        while (!res_valid && budget < 100) begin
            if (add_en && !add_rw) begin
                if (rd_n < 16) begin
                    amask[rd_n] = add_a;
                    bmask[rd_n] = add_b;
                end
                rd_n++;
            end else if (add_en && add_rw) begin
                wr_n++;
                if (add_a || add_b) bad_w++;
            end
            tick();
            budget++;
        end
        check({tag, "_done_seen"}, {31'b0, res_valid}, 32'd1);
        // res_valid is registered on edge k+2L+DL, i.e. visible in cycle k+32
        check({tag, "_latency"}, edge_cnt - k, 2 * L + DL);
        check({tag, "_read_cycles"}, rd_n, L);
        check({tag, "_write_cycles"}, wr_n, L + DL);
        check({tag, "_a_stream"}, {16'b0, amask}, {16'b0, am});
        check({tag, "_b_stream"}, {16'b0, bmask}, {16'b0, bm});
        check({tag, "_write_ab_low"}, bad_w, 0);
        check({tag, "_done_en"}, {30'b0, add_en, op_ready}, 32'd0);
        check({tag, "_sum"}, {27'b0, res_sum}, {27'b0, es});
        check({tag, "_ovf"}, {31'b0, res_ovf}, {31'b0, eo});
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_consumed"}, {28'b0, res_valid, op_ready, add_rst_n, add_en}, 32'b0100);
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [4:0]  sum;
        logic        ovf;
        logic [15:0] am;
        logic [15:0] bm;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k, k2, budget;
        string tag;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  sum: 5'd8,  ovf: 1'b0, am: 16'h0007, bm: 16'h001F};
        vecs[1] = '{a: 4'd15, b: 4'd15, sum: 5'd15, ovf: 1'b1, am: 16'h7FFF, bm: 16'h7FFF};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  sum: 5'd0,  ovf: 1'b0, am: 16'h0000, bm: 16'h0000};
        vecs[3] = '{a: 4'd15, b: 4'd0,  sum: 5'd15, ovf: 1'b0, am: 16'h7FFF, bm: 16'h0000};
        vecs[4] = '{a: 4'd9,  b: 4'd7,  sum: 5'd15, ovf: 1'b1, am: 16'h01FF, bm: 16'h007F};
        vecs[5] = '{a: 4'd1,  b: 4'd14, sum: 5'd15, ovf: 1'b0, am: 16'h0001, bm: 16'h3FFF};
        vecs[6] = '{a: 4'd7,  b: 4'd0,  sum: 5'd7,  ovf: 1'b0, am: 16'h007F, bm: 16'h0000};

        rst_n = 1'b0;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        res_ready = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("idle_after_reset");

        // Table of directed operations
        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            start_op(vecs[i].a, vecs[i].b, 1'b0, k);
            finish_op(tag, k, vecs[i].sum, vecs[i].ovf, vecs[i].am, vecs[i].bm);
            consume(tag);
        end

        // Result held while the consumer stalls; pending operands wait
        start_op(4'd2, 4'd3, 1'b0, k);
        finish_op("stall", k, 5'd5, 1'b0, 16'h0003, 16'h0007);
        op_a = 4'd1;
        op_b = 4'd1;
        op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", {25'b0, res_valid, op_ready, res_sum}, {25'b0, 1'b1, 1'b0, 5'd5});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("stall_release", {25'b0, res_valid, op_ready, res_sum}, {25'b0, 1'b0, 1'b1, 5'd5});
        start_op(4'd1, 4'd1, 1'b0, k);
        finish_op("stall_next", k, 5'd2, 1'b0, 16'h0001, 16'h0001);
        consume("stall_next");

        // Reset pulsed in WRITE cycle 4 discards the operation
        start_op(4'd6, 4'd6, 1'b0, k);
        for (int i = 0; i < L + 4; i++) tick();
        check("mid_write_phase", {30'b0, add_en, add_rw}, 32'b11);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        check_reset_outputs("reset_released");
        start_op(4'd2, 4'd2, 1'b0, k);
        finish_op("post_reset", k, 5'd4, 1'b0, 16'h0003, 16'h0003);
        consume("post_reset");

        // Back-to-back operations with the consumer always ready
        res_ready = 1'b1;
        start_op(4'd1, 4'd2, 1'b1, k);
        budget = 0;
        while (!op_ready && budget < 100) begin
            tick();
            budget++;
        end
        tick();
        k2 = edge_cnt;
        op_valid = 1'b0;
        check("throughput", k2 - k, 2 * L + DL + 2);
        for (int i = 0; i < 2 * L + DL + 4; i++) tick();
        check("throughput_drain", {30'b0, res_valid, op_ready}, 32'b01);
        res_ready = 1'b0;

`ifdef UNARY_SEQ_ABORT_EN
        // Abort in READ cycle 7 returns to IDLE with no result
        start_op(4'd4, 4'd4, 1'b0, k);
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {28'b0, add_en, add_rst_n, op_ready, res_valid}, 32'b0010);
        for (int i = 0; i < 40; i++) tick();
        check("abort_no_result", {30'b0, res_valid, op_ready}, 32'b01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
